// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin arbiter sharing one common data bus among per-source result FIFOs
//
// Ports:
//   clk_in      system clock
//   rst_in      asynchronous reset, active-low
//   rdy_in      global enable; low freezes every register
//   clear       mispredict flush (only honoured while rdy_in=1)
//   src_valid   per-source result strobe
//   src_rob_id  per-source tag, source i at [i*ROB_W +: ROB_W]
//   src_value   per-source value, source i at [i*32 +: 32]
//   src_full    per-source FIFO full (decoded from registered count)
//   cdb_ready   registered broadcast valid
//   cdb_rob_id  registered broadcast tag
//   cdb_value   registered broadcast value
//
// Optional feature macro: CDB_BYPASS_EN
//   When defined, a source with an empty FIFO that strobes this cycle may win
//   the grant directly; its input goes straight to the CDB registers.

module cdb_arbiter #(
    parameter int NUM_SRC    = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int ROB_W      = 4
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     clear,
    input  logic [NUM_SRC-1:0]       src_valid,
    input  logic [NUM_SRC*ROB_W-1:0] src_rob_id,
    input  logic [NUM_SRC*32-1:0]    src_value,
    output logic [NUM_SRC-1:0]       src_full,
    output logic                     cdb_ready,
    output logic [ROB_W-1:0]         cdb_rob_id,
    output logic [31:0]              cdb_value
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int ENT_W = ROB_W + 32;

    logic [ENT_W-1:0] mem    [NUM_SRC][FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr [NUM_SRC];
    logic [PTR_W-1:0] rd_ptr [NUM_SRC];
    logic [CNT_W-1:0] count  [NUM_SRC];
    logic [SEL_W-1:0] rr_ptr;

    logic [ENT_W-1:0]   in_ent [NUM_SRC];
    logic [NUM_SRC-1:0] nonempty;
    logic [NUM_SRC-1:0] cand;
    logic [NUM_SRC-1:0] push;
    logic [NUM_SRC-1:0] pop;
    logic               grant_valid;
    logic               fwd;
    logic [SEL_W-1:0]   winner;
    logic [SEL_W-1:0]   rr_next;
    logic [ENT_W-1:0]   head;

    // Per-source decode of input entry and registered FIFO status.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            in_ent[i]   = {src_rob_id[i*ROB_W +: ROB_W], src_value[i*32 +: 32]};
            nonempty[i] = (count[i] != '0);
            src_full[i] = (count[i] == CNT_W'(FIFO_DEPTH));
        end
    end

`ifdef CDB_BYPASS_EN
    assign cand = nonempty | src_valid;
`else
    assign cand = nonempty;
`endif

    // Round-robin pick. Offsets are scanned from farthest to nearest so the
    // candidate closest to rr_ptr is the last (winning) assignment.
    always_comb begin
        int               idx;
        logic [SEL_W-1:0] idx_s;
        grant_valid = 1'b0;
        winner      = rr_ptr;
        idx         = 0;
        idx_s       = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_SRC) begin
                idx = idx - NUM_SRC;
            end
            idx_s = SEL_W'(idx);
            if (cand[idx_s]) begin
                grant_valid = 1'b1;
                winner      = idx_s;
            end
        end
    end

    // Broadcast source: FIFO head, or the live input when the winner's FIFO is
    // empty (only reachable with bypass enabled).
    always_comb begin
        head = mem[winner][rd_ptr[winner]];
        fwd  = 1'b0;
`ifdef CDB_BYPASS_EN
        if (!nonempty[winner]) begin
            fwd  = grant_valid;
            head = in_ent[winner];
        end
`endif
    end

    // A forwarded strobe is consumed by the CDB and must not also be queued.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            pop[i]  = grant_valid && (winner == SEL_W'(i)) && nonempty[i];
            push[i] = src_valid[i] && !src_full[i] && !(fwd && (winner == SEL_W'(i)));
        end
        rr_next = (winner == SEL_W'(NUM_SRC - 1)) ? '0 : winner + SEL_W'(1);
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
            rr_ptr     <= '0;
            cdb_ready  <= 1'b0;
            cdb_rob_id <= '0;
            cdb_value  <= '0;
        end else if (rdy_in) begin
            if (clear) begin
                for (int i = 0; i < NUM_SRC; i++) begin
                    wr_ptr[i] <= '0;
                    rd_ptr[i] <= '0;
                    count[i]  <= '0;
                end
                rr_ptr    <= '0;
                cdb_ready <= 1'b0;
            end else begin
                for (int i = 0; i < NUM_SRC; i++) begin
                    if (push[i]) begin
                        wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                    end
                    if (pop[i]) begin
                        rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                    end
                    count[i] <= count[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
                end
                cdb_ready <= grant_valid;
                if (grant_valid) begin
                    {cdb_rob_id, cdb_value} <= head;
                    rr_ptr                  <= rr_next;
                end
            end
        end
    end

    // Storage carries no reset; validity is tracked entirely by count/pointers.
    always_ff @(posedge clk_in) begin
        if (rdy_in && !clear) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (push[i]) begin
                    mem[i][wr_ptr[i]] <= in_ent[i];
                end
            end
        end
    end

    a_no_strobe_when_full: assert property (
        @(posedge clk_in) disable iff (!rst_in)
        (rdy_in && !clear) |-> ((src_valid & src_full) == '0)
    ) else $error("cdb_arbiter: strobe into full FIFO, entry dropped");

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - randomized and directed bench for cdb_arbiter against a queue-based model

module tb_cdb_arbiter;

    localparam int NS    = 2;
    localparam int DEPTH = 4;
    localparam int RW    = 4;
    localparam int EW    = RW + 32;
    localparam int OW    = 1 + RW + 32 + NS;
`ifdef CDB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b0;
    logic          rdy_in = 1'b1;
    logic          clear  = 1'b0;
    logic [1:0]    src_valid  = '0;
    logic [7:0]    src_rob_id = '0;
    logic [63:0]   src_value  = '0;
    logic [1:0]    src_full;
    logic          cdb_ready;
    logic [RW-1:0] cdb_rob_id;
    logic [31:0]   cdb_value;

    int ncmp  = 0;
    int nfail = 0;

    always #5 clk_in = ~clk_in;

    cdb_arbiter #(.NUM_SRC(NS), .FIFO_DEPTH(DEPTH), .ROB_W(RW)) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .rdy_in     (rdy_in),
        .clear      (clear),
        .src_valid  (src_valid),
        .src_rob_id (src_rob_id),
        .src_value  (src_value),
        .src_full   (src_full),
        .cdb_ready  (cdb_ready),
        .cdb_rob_id (cdb_rob_id),
        .cdb_value  (cdb_value)
    );

    wire [OW-1:0] obs = {cdb_ready, cdb_rob_id, cdb_value, src_full};

    // Reference model: one queue per source plus the next source to favour.
    logic [EW-1:0] mq [NS][$];
    int            m_rr;
    logic          m_ready;
    logic [RW-1:0] m_id;
    logic [31:0]   m_val;

    function automatic logic [OW-1:0] expv();
        logic [NS-1:0] f;
        for (int i = 0; i < NS; i++) f[i] = (mq[i].size() == DEPTH);
        return {m_ready, m_id, m_val, f};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NS; i++) mq[i].delete();
        m_rr = 0; m_ready = 1'b0; m_id = '0; m_val = '0;
    endtask

    task automatic model_edge();
        int            win;
        logic [EW-1:0] e;
        logic [NS-1:0] acc;
        if (!rst_in || !rdy_in) return;
        if (clear) begin
            for (int i = 0; i < NS; i++) mq[i].delete();
            m_rr = 0; m_ready = 1'b0;
            return;
        end
        win = -1;
        for (int k = 0; k < NS; k++) begin
            int i;
            i = (m_rr + k) % NS;
            if (win < 0 && (mq[i].size() > 0 || (BYP && src_valid[i]))) win = i;
        end
        for (int i = 0; i < NS; i++) acc[i] = src_valid[i] && (mq[i].size() < DEPTH);
        m_ready = (win >= 0);
        if (win >= 0) begin
            if (mq[win].size() > 0) begin
                e = mq[win].pop_front();
            end else begin
                e = {src_rob_id[win*RW +: RW], src_value[win*32 +: 32]};
                acc[win] = 1'b0;
            end
            {m_id, m_val} = e;
            m_rr = (win + 1) % NS;
        end
        for (int i = 0; i < NS; i++)
            if (acc[i]) mq[i].push_back({src_rob_id[i*RW +: RW], src_value[i*32 +: 32]});
    endtask

    task automatic tick(input logic [1:0] v, input logic [7:0] id, input logic [63:0] val,
                        input logic clr, input logic rdy);
        src_valid = v; src_rob_id = id; src_value = val; clear = clr; rdy_in = rdy;
        @(posedge clk_in);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        #12;
        ncmp++;
        if (obs !== '0) begin nfail++; $display("FAIL reset_state: got %h want %h", obs, {OW{1'b0}}); end
        rst_in = 1'b1;
        for (int n = 0; n < 2; n++) begin
            tick(2'b00, 8'h00, 64'h0, 1'b0, 1'b1);
            ncmp++;
            if (obs !== expv()) begin nfail++; $display("FAIL reset_idle: got %h want %h", obs, expv()); end
        end
    endtask

    task automatic test_single();
        int hit;
        logic [36:0] want;
        hit = BYP ? 0 : 1;
        for (int n = 0; n < 3; n++) begin
            tick((n == 0) ? 2'b01 : 2'b00, 8'h05, 64'h0000_0000_0000_1234, 1'b0, 1'b1);
            want = {(n == hit), (n >= hit) ? 4'd5 : 4'd0, (n >= hit) ? 32'h1234 : 32'h0};
            ncmp++;
            if ({cdb_ready, cdb_rob_id, cdb_value} !== want) begin
                nfail++; $display("FAIL single_latency n=%0d: got %h want %h", n, {cdb_ready, cdb_rob_id, cdb_value}, want);
            end
            ncmp++;
            if (obs !== expv()) begin nfail++; $display("FAIL single_model: got %h want %h", obs, expv()); end
        end
    endtask

    task automatic test_contention();
        logic [RW-1:0] ids[$];
        tick(2'b00, 8'h00, 64'h0, 1'b1, 1'b1);
        for (int n = 0; n < 12; n++) begin
            if (n < 4) tick(2'b11, {4'd2, 4'd1}, {32'hB, 32'hA}, 1'b0, 1'b1);
            else       tick(2'b00, 8'h00, 64'h0, 1'b0, 1'b1);
            if (cdb_ready) ids.push_back(cdb_rob_id);
            ncmp++;
            if (obs !== expv()) begin nfail++; $display("FAIL contention_model: got %h want %h", obs, expv()); end
        end
        ncmp++;
        if (ids.size() != 8) begin nfail++; $display("FAIL contention_count: got %0d want 8", ids.size()); end
        for (int j = 0; j < ids.size() && j < 8; j++) begin
            ncmp++;
            if (ids[j] !== ((j % 2 == 0) ? 4'd1 : 4'd2)) begin
                nfail++; $display("FAIL contention_order j=%0d: got %0d want %0d", j, ids[j], (j % 2 == 0) ? 1 : 2);
            end
        end
    endtask

    task automatic test_backpressure();
        int          sent0, sent1;
        bit          seen_full;
        logic [1:0]  v;
        logic [31:0] lg[$];
        sent0 = 0; sent1 = 0; seen_full = 1'b0;
        for (int c = 0; c < 80; c++) begin
            if (src_full[1]) seen_full = 1'b1;
            v[0] = (sent0 < 12) && !src_full[0];
            v[1] = (sent1 < 10) && !src_full[1];
            tick(v, {4'(sent1), 4'hF}, {32'h1000_0000 + 32'(sent1), 32'(sent0)}, 1'b0, 1'b1);
            sent0 += int'(v[0]);
            sent1 += int'(v[1]);
            if (cdb_ready && cdb_value[31:28] == 4'h1) lg.push_back(cdb_value);
            ncmp++;
            if (obs !== expv()) begin nfail++; $display("FAIL backpressure_model: got %h want %h", obs, expv()); end
        end
        ncmp++;
        if (seen_full !== 1'b1) begin nfail++; $display("FAIL backpressure_full_seen: got %0d want 1", seen_full); end
        ncmp++;
        if (lg.size() != 10) begin nfail++; $display("FAIL backpressure_count: got %0d want 10", lg.size()); end
        for (int k = 0; k < lg.size() && k < 10; k++) begin
            ncmp++;
            if (lg[k] !== 32'h1000_0000 + 32'(k)) begin
                nfail++; $display("FAIL backpressure_order k=%0d: got %h want %h", k, lg[k], 32'h1000_0000 + 32'(k));
            end
        end
    endtask

    task automatic test_flush();
        int first_id;
        for (int n = 0; n < 2; n++) begin
            tick(2'b11, {4'd4, 4'd3}, {32'h44, 32'h33}, 1'b0, 1'b1);
            ncmp++;
            if (obs !== expv()) begin nfail++; $display("FAIL flush_fill: got %h want %h", obs, expv()); end
        end
        tick(2'b11, {4'd7, 4'd6}, {32'h77, 32'h66}, 1'b1, 1'b1);
        ncmp++;
        if (cdb_ready !== 1'b0) begin nfail++; $display("FAIL flush_ready: got %0d want 0", cdb_ready); end
        for (int n = 0; n < 3; n++) begin
            tick(2'b00, 8'h00, 64'h0, 1'b0, 1'b1);
            ncmp++;
            if (cdb_ready !== 1'b0) begin nfail++; $display("FAIL flush_quiet n=%0d: got %0d want 0", n, cdb_ready); end
        end
        first_id = -1;
        for (int n = 0; n < 4; n++) begin
            if (n == 0) tick(2'b11, {4'd9, 4'd8}, {32'h99, 32'h88}, 1'b0, 1'b1);
            else        tick(2'b00, 8'h00, 64'h0, 1'b0, 1'b1);
            if (cdb_ready && first_id < 0) first_id = int'(cdb_rob_id);
            ncmp++;
            if (obs !== expv()) begin nfail++; $display("FAIL flush_model: got %h want %h", obs, expv()); end
        end
        ncmp++;
        if (first_id != 8) begin nfail++; $display("FAIL flush_rr_restart: got %0d want 8", first_id); end
    endtask

    task automatic test_stall();
        for (int n = 0; n < 3; n++) begin
            tick(2'b11, {4'd2, 4'd1}, {32'h22 + 32'(n), 32'h11 + 32'(n)}, 1'b0, 1'b1);
            ncmp++;
            if (obs !== expv()) begin nfail++; $display("FAIL stall_fill: got %h want %h", obs, expv()); end
        end
        for (int n = 0; n < 3; n++) begin
            tick(2'b11, {4'd7, 4'd6}, {32'h77, 32'h66}, 1'b1, 1'b0);
            ncmp++;
            if (cdb_ready !== 1'b1) begin nfail++; $display("FAIL stall_ready n=%0d: got %0d want 1", n, cdb_ready); end
            ncmp++;
            if (obs !== expv()) begin nfail++; $display("FAIL stall_frozen: got %h want %h", obs, expv()); end
        end
        for (int n = 0; n < 8; n++) begin
            tick(2'b00, 8'h00, 64'h0, 1'b0, 1'b1);
            ncmp++;
            if (obs !== expv()) begin nfail++; $display("FAIL stall_resume: got %h want %h", obs, expv()); end
        end
    endtask

    task automatic test_random();
        logic [1:0]  v;
        logic [7:0]  id;
        logic [63:0] val;
        logic        clr, rdy;
        for (int n = 0; n < 400; n++) begin
            v   = 2'($urandom_range(0, 3));
            for (int i = 0; i < NS; i++) if (mq[i].size() >= DEPTH) v[i] = 1'b0;
            id  = 8'($urandom);
            val = {$urandom, $urandom};
            clr = ($urandom_range(0, 39) == 0);
            rdy = ($urandom_range(0, 7) != 0);
            tick(v, id, val, clr, rdy);
            ncmp++;
            if (obs !== expv()) begin nfail++; $display("FAIL random n=%0d: got %h want %h", n, obs, expv()); end
        end
        for (int n = 0; n < 10; n++) begin
            tick(2'b00, 8'h00, 64'h0, 1'b0, 1'b1);
            ncmp++;
            if (obs !== expv()) begin nfail++; $display("FAIL random_drain: got %h want %h", obs, expv()); end
        end
    endtask

    task automatic test_reset_mid();
        for (int n = 0; n < 2; n++) tick(2'b11, {4'd3, 4'd2}, {32'h5555, 32'h4444}, 1'b0, 1'b1);
        ncmp++;
        if (mq[0].size() + mq[1].size() != 3) begin
            nfail++; $display("FAIL reset_mid_setup: got %0d want 3", mq[0].size() + mq[1].size());
        end
        #2 rst_in = 1'b0;
        model_reset();
        #1;
        ncmp++;
        if (obs !== '0) begin nfail++; $display("FAIL reset_mid_async: got %h want %h", obs, {OW{1'b0}}); end
        @(posedge clk_in);
        #2 rst_in = 1'b1;
        for (int n = 0; n < 4; n++) begin
            tick(2'b00, 8'h00, 64'h0, 1'b0, 1'b1);
            ncmp++;
            if (obs !== '0) begin nfail++; $display("FAIL reset_mid_stale n=%0d: got %h want %h", n, obs, {OW{1'b0}}); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_flush();
        test_stall();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
